// File: rtl/arbitro_memoria.sv
// arbitro_memoria: arbitrates fetch vs data access to a single-port synchronous memory with fixed read latency; ARBITRO_ANTI_FOME_EN enables fetch anti-starvation
module arbitro_memoria #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LAT     = 1,
    parameter int MAX_SEQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {OCIOSO, EMITE, ESPERA, RESP} state_t;

    if (LAT < 1 || LAT > 3 || MAX_SEQ < 1) begin : g_bad_param
        $error("arbitro_memoria: LAT must be 1..3 and MAX_SEQ >= 1");
    end

    state_t            state, state_next;
    logic [1:0]        cnt, cnt_next;
    logic              dono, dono_next;
    logic              we_q, we_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic              grant_dm;

`ifdef ARBITRO_ANTI_FOME_EN
    localparam int SEQ_W = $clog2(MAX_SEQ) + 1;
    logic [SEQ_W-1:0] seq, seq_next;

    assign grant_dm = dm_req && !(if_req && seq == SEQ_W'(MAX_SEQ));

    // count consecutive data grants that made a waiting fetch lose
    always_comb begin
        seq_next = seq;
        if (state == OCIOSO && (if_req || dm_req))
            seq_next = (grant_dm && if_req) ? seq + SEQ_W'(1) : '0;
    end

    // anti-starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq <= '0;
        else        seq <= seq_next;
    end
`else
    assign grant_dm = dm_req;
`endif

    // sequencing: sample winner, issue once, wait out the latency, acknowledge
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dono_next  = dono;
        we_next    = we_q;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        case (state)
            OCIOSO: if (if_req || dm_req) begin
                state_next = EMITE;
                dono_next  = grant_dm;
                we_next    = grant_dm && dm_we;
                addr_next  = grant_dm ? dm_addr : if_addr;
                wdata_next = grant_dm ? dm_wdata : mem_wdata;
            end
            EMITE: begin
                cnt_next   = 2'(LAT - 1);
                state_next = (LAT == 1) ? RESP : ESPERA;
            end
            ESPERA: begin
                cnt_next   = cnt - 2'd1;
                state_next = (cnt == 2'd1) ? RESP : ESPERA;
            end
            default: state_next = OCIOSO;
        endcase
    end

    // state, access context and registered strobes decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OCIOSO;
            cnt       <= '0;
            dono      <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            dono      <= dono_next;
            we_q      <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            mem_en    <= state_next == EMITE;
            mem_we    <= state_next == EMITE && we_next;
            if_ack    <= state_next == RESP && !dono_next;
            dm_ack    <= state_next == RESP && dono_next;
        end
    end

    assign if_rdata = if_ack ? mem_rdata : '0;
    assign dm_rdata = (dm_ack && !we_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: randomized and directed checks of arbitro_memoria against a transaction-level model
module tb_arbitro_memoria;
    localparam int L0 = 1;
    localparam int L1 = 3;
    localparam int MS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, rst1_n;
    logic        if_req0, dm_req0, dm_we0, if_ack0, dm_ack0, mem_en0, mem_we0;
    logic [7:0]  if_addr0, dm_addr0, mem_addr0;
    logic [15:0] dm_wdata0, if_rdata0, dm_rdata0, mem_wdata0, mem_rdata0;
    logic        if_req1, dm_req1, dm_we1, if_ack1, dm_ack1, mem_en1, mem_we1;
    logic [7:0]  if_addr1, dm_addr1, mem_addr1;
    logic [15:0] dm_wdata1, if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;

    arbitro_memoria #(.ADDR_W(8), .DATA_W(16), .LAT(L0), .MAX_SEQ(MS)) u0 (
        .clk(clk), .rst_n(rst0_n),
        .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_rdata(if_rdata0),
        .dm_req(dm_req0), .dm_we(dm_we0), .dm_addr(dm_addr0), .dm_wdata(dm_wdata0),
        .dm_ack(dm_ack0), .dm_rdata(dm_rdata0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    arbitro_memoria #(.ADDR_W(8), .DATA_W(16), .LAT(L1), .MAX_SEQ(MS)) u1 (
        .clk(clk), .rst_n(rst1_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_ack(dm_ack1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    function automatic logic [15:0] init_val(int i);
        return (i == 16) ? 16'hBEEF : (16'(i * 257) ^ 16'h5A5A);
    endfunction

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] pipe0;
    logic [15:0] pipe1 [3];

    // memory for u0: one-cycle read latency, idle cycles return a junk pattern
    always @(posedge clk) begin
        if (!rst0_n) for (int i = 0; i < 256; i++) mem0[i] <= init_val(i);
        else if (mem_en0 && mem_we0) mem0[mem_addr0] <= mem_wdata0;
        pipe0 <= (mem_en0 && !mem_we0) ? mem0[mem_addr0] : 16'hDEAD;
    end

    // memory for u1: three-cycle read latency
    always @(posedge clk) begin
        if (!rst1_n) for (int i = 0; i < 256; i++) mem1[i] <= init_val(i);
        else if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
        pipe1[0] <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : 16'hDEAD;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    assign mem_rdata0 = pipe0;
    assign mem_rdata1 = pipe1[2];

    int total = 0, bad = 0;
    int cyc, free_at, g_issue, g_ack, mode;
    logic g_who, g_we, if_act, dm_act, rec;
    logic [7:0]  g_addr;
    logic [15:0] g_exp, g_wd;
    logic [15:0] ref0 [256];
    int order[$];
`ifdef ARBITRO_ANTI_FOME_EN
    int seq = 0;
`endif

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic req_if(logic [7:0] a);
        if_act = 1'b1; if_req0 = 1'b1; if_addr0 = a;
    endtask

    task automatic req_dm(logic we, logic [7:0] a, logic [15:0] d);
        dm_act = 1'b1; dm_req0 = 1'b1; dm_we0 = we; dm_addr0 = a; dm_wdata0 = d;
    endtask

    task automatic step();
        logic w;
        if (cyc >= free_at && (if_req0 || dm_req0)) begin
            w = dm_req0;
`ifdef ARBITRO_ANTI_FOME_EN
            if (if_req0 && dm_req0 && seq == MS) w = 1'b0;
            seq = (w && if_req0) ? seq + 1 : 0;
`endif
            g_who = w;
            g_we = w && dm_we0;
            g_addr = w ? dm_addr0 : if_addr0;
            g_wd = dm_wdata0;
            g_exp = ref0[g_addr];
            if (g_we) ref0[g_addr] = dm_wdata0;
            g_issue = cyc + 1;
            g_ack = cyc + 1 + L0;
            free_at = cyc + 2 + L0;
        end
        @(posedge clk); #1; cyc++;
        chk("mem_en", mem_en0, cyc == g_issue);
        chk("mem_we", mem_we0, cyc == g_issue && g_we);
        if (cyc == g_issue) begin
            chk("mem_addr", mem_addr0, g_addr);
            if (g_we) chk("mem_wdata", mem_wdata0, g_wd);
        end
        chk("if_ack", if_ack0, cyc == g_ack && !g_who);
        chk("dm_ack", dm_ack0, cyc == g_ack && g_who);
        chk("if_rdata", if_rdata0, (cyc == g_ack && !g_who) ? g_exp : 16'h0);
        chk("dm_rdata", dm_rdata0, (cyc == g_ack && g_who && !g_we) ? g_exp : 16'h0);
        if (rec && if_ack0) order.push_back(0);
        if (rec && dm_ack0) order.push_back(1);
        if (cyc == g_ack) begin
            if (g_who) dm_act = 1'b0;
            else if_act = 1'b0;
        end
        if (mode == 1) begin
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1'b1; if_addr0 = 8'($urandom);
            end
            if (!dm_act && $urandom_range(0, 2) == 0) begin
                dm_act = 1'b1; dm_we0 = 1'($urandom_range(0, 1));
                dm_addr0 = 8'($urandom_range(0, 15)); dm_wdata0 = 16'($urandom);
            end
        end
        if (mode == 2) begin
            if_act = 1'b1; dm_act = 1'b1;
        end
        if_req0 = if_act;
        dm_req0 = dm_act;
    endtask

    task automatic drain();
        int n = 0;
        mode = 0;
        while ((if_act || dm_act || cyc < free_at) && n < 60) begin
            step();
            n++;
        end
        chk("drain_bound", n < 60, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cyc = 0; free_at = 0; g_issue = -1; g_ack = -1; mode = 0; rec = 1'b0;
        g_who = 1'b0; g_we = 1'b0; g_addr = '0; g_exp = '0; g_wd = '0;
        if_act = 1'b0; dm_act = 1'b0;
        if_req0 = 0; dm_req0 = 0; dm_we0 = 0; if_addr0 = 0; dm_addr0 = 0; dm_wdata0 = 0;
        if_req1 = 0; dm_req1 = 0; dm_we1 = 0; if_addr1 = 0; dm_addr1 = 0; dm_wdata1 = 0;
        for (int i = 0; i < 256; i++) ref0[i] = init_val(i);
        rst0_n = 1'b0; rst1_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en0, 0);
        chk("rst_acks", {if_ack0, dm_ack0, mem_we0}, 0);
        chk("rst_mem_addr", mem_addr0, 0);
        chk("rst_mem_wdata", mem_wdata0, 0);
        rst0_n = 1'b1; rst1_n = 1'b1;

        req_if(8'h10);
        step(); step();
        chk("fetch_beef", if_rdata0, 16'hBEEF);
        drain();

        req_if(8'h30); req_dm(1'b0, 8'h20, 16'h0);
        drain();

        req_dm(1'b1, 8'h05, 16'h1234);
        drain();
        req_dm(1'b0, 8'h05, 16'h0);
        step(); step();
        chk("read_after_write", dm_rdata0, 16'h1234);
        drain();

        req_dm(1'b0, 8'h07, 16'h0);
        step();
        dm_act = 1'b0; dm_req0 = 1'b0;
        step();
        chk("early_drop_ack", dm_ack0, 1);
        drain();

        mode = 1;
        repeat (600) step();
        drain();

        mode = 2; rec = 1'b1; n = 0;
        order.delete();
        while (order.size() < 10 && n < 200) begin
            step();
            n++;
        end
        rec = 1'b0;
        drain();
        chk("order_len", order.size(), 10);
        for (int i = 0; i < order.size() && i < 10; i++)
`ifdef ARBITRO_ANTI_FOME_EN
            chk("grant_order", order[i], (i % 5 == 4) ? 0 : 1);
`else
            chk("grant_order", order[i], 1);
`endif

        dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 8'h42;
        step(); chk("l3_issue", mem_en1, 1);
        step(); chk("l3_no_ack_a", dm_ack1, 0);
        step(); chk("l3_no_ack_b", dm_ack1, 0);
        step(); chk("l3_ack", dm_ack1, 1);
        chk("l3_data", dm_rdata1, init_val(8'h42));
        dm_addr1 = 8'h43;
        step(); chk("l3_idle", mem_en1, 0);
        step(); chk("l3_issue2", mem_en1, 1);
        step();
        rst1_n = 1'b0;
        #1;
        chk("l3_rst_en", {mem_en1, mem_we1, if_ack1, dm_ack1}, 0);
        chk("l3_rst_addr", mem_addr1, 0);
        chk("l3_rst_wdata", mem_wdata1, 0);
        chk("l3_rst_rdata", {if_rdata1, dm_rdata1}, 0);
        repeat (3) begin
            step(); chk("l3_rst_no_ack", dm_ack1, 0);
        end
        rst1_n = 1'b1;
        step(); chk("l3_post_issue", mem_en1, 1);
        step(); step(); chk("l3_post_early", dm_ack1, 0);
        step(); chk("l3_post_ack", dm_ack1, 1);
        chk("l3_post_data", dm_rdata1, init_val(8'h43));
        dm_req1 = 1'b0;
        step(); chk("l3_post_single", dm_ack1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Arbiter and sequencer for the processor's single-port synchronous memory. Two requesters share it: instruction fetch (`if_*`) and data load/store (`dm_*`). The block grants one access at a time, drives the memory port for one issue cycle, counts the fixed read latency and returns a one-cycle acknowledge with data to the winner. It sits between the control unit/datapath and the memory.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 16: data width.
- `LAT`, 1: memory read latency in cycles, legal 1..3. `mem_rdata` is valid `LAT` cycles after the issue cycle.
- `MAX_SEQ`, 4: maximum consecutive data grants while fetch waits. Only used with `ARBITRO_ANTI_FOME_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_ack`.
- `if_addr` in ADDR_W: fetch address; stable while `if_req`.
- `if_ack` out 1: one-cycle completion pulse.
- `if_rdata` out DATA_W: fetch data; equals `mem_rdata` when `if_ack`=1, else 0.
- `dm_req` in 1: data request; held until `dm_ack`.
- `dm_we` in 1: 1 = write, 0 = read; stable while `dm_req`.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: write data.
- `dm_ack` out 1: one-cycle completion pulse.
- `dm_rdata` out DATA_W: equals `mem_rdata` when `dm_ack`=1 and `dm_we`=0, else 0.
- `mem_en` out 1: memory access strobe, high for the issue cycle only.
- `mem_we` out 1: write strobe, high only with `mem_en` for data writes.
- `mem_addr` out ADDR_W: registered address; holds its last value outside issue.
- `mem_wdata` out DATA_W: registered write data; holds its last value.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- The FSM has four states: OCIOSO, EMITE, ESPERA and RESP.
- **OCIOSO:** samples requests. If any request is present, it registers the winner's address, write flag and write data, and records the winner in `dono` (0 = if, 1 = dm). Next state is EMITE.
- **EMITE:** `mem_en`=1, and `mem_we`=`dm_we` if `dono`=dm, else 0. The latency counter loads `LAT-1`. Next state is RESP if `LAT`=1, else ESPERA.
- **ESPERA:** decrements the counter and goes to RESP when it reaches 1.
- **RESP:** pulses the owner's ack for one cycle, then returns to OCIOSO.
- **Arbitration:** data has fixed priority over fetch when both requests are present in OCIOSO. The exception is the anti-starvation rule below.
- **Request hold:** a requester keeps its request high until its ack. A request still high in the cycle after the ack is treated as a new access.
- **Protocol violation:** if a requester drops its request before the ack, the access still completes and the ack still pulses.
- **Outputs:** ack and `mem_*` strobes are registered (driven by state). Read data is passed combinationally from `mem_rdata`, gated by ack.
- **Reset values:** all outputs 0, state OCIOSO, counters 0, `dono`=0.
- **Reset mid-access:** the access is aborted, no ack is issued, and the memory state is not guaranteed for an aborted write.

## Timing
- A request is sampled in OCIOSO in cycle N. EMITE (issue) is cycle N+1, ack is in cycle N+1+`LAT`, and OCIOSO is cycle N+2+`LAT`.
- Minimum spacing between issues is `LAT`+2 cycles. With `LAT`=1 and fetch requesting continuously, `mem_en` is high in cycles 1, 4, 7, ...
- A request arriving during EMITE, ESPERA or RESP waits. It is evaluated in the next OCIOSO cycle.
- Exactly one of `if_ack`/`dm_ack` may be high in any cycle. `mem_en` is never high in two consecutive cycles.

## Configuration
- `ARBITRO_ANTI_FOME_EN` defined: a counter `seq` (width clog2(`MAX_SEQ`)+1) tracks consecutive dm grants.
  - `seq` increments on each dm grant made while `if_req`=1.
  - `seq` clears on any if grant, or on a dm grant made with `if_req`=0.
  - When both requests are present and `seq`==`MAX_SEQ`, fetch wins and `seq` clears.
- `ARBITRO_ANTI_FOME_EN` undefined: strict data priority; no counter logic.

## Test plan
- **Single fetch:** `LAT`=1, `if_req`=1, `if_addr`=0x10, memory[0x10]=0xBEEF. Required: `mem_en` in cycle 1, `if_ack`=1 with `if_rdata`=0xBEEF in cycle 2, `dm_ack` never asserted.
- **Simultaneous requests:** `if_req` and `dm_req` (read, 0x20) rise in cycle 0. Required: dm is served first with `dm_ack` in cycle 2. Fetch issues in cycle 4 and `if_ack` follows in cycle 5.
- **Data write:** `dm_we`=1, `dm_addr`=0x05, `dm_wdata`=0x1234. Required: `mem_we`=`mem_en`=1 in the same single cycle, `dm_ack` pulses, `dm_rdata`=0, and a later read of 0x05 returns 0x1234.
- **Anti-starvation, macro defined:** `MAX_SEQ`=4, `if_req` and `dm_req` held high continuously. Required grant order: dm, dm, dm, dm, if, dm, dm, dm, dm, if.
- **Anti-starvation, macro undefined:** same stimulus as the previous scenario. Required: `if_ack` is never asserted while `dm_req` stays high.
- **Latency and reset:** `LAT`=3, read issued in cycle 1. Required: `dm_ack` in cycle 4. Then `rst_n`=0 during ESPERA of a second access. Required: all outputs 0 immediately, no ack, and a fresh request after reset is served normally.
